// File: rtl/vga_bram_arbiter.sv
// Frame-buffer BRAM port arbiter: display scan-out has priority over the host path.
// Optional host starvation guard compiled in with `define VGA_BRAM_ARB_STARVE_GUARD_EN.
module vga_bram_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  if (RD_LAT < 1 || RD_LAT > 3 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_check
    $error("vga_bram_arbiter: RD_LAT must be 1..3 and STARVE_LIMIT 1..255");
  end

  logic disp_gnt_c;
  logic host_gnt_c;
  logic rd_issue;

`ifdef VGA_BRAM_ARB_STARVE_GUARD_EN
  typedef enum logic {
    ST_DISP_PRI   = 1'b0,
    ST_HOST_FORCE = 1'b1
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state_q;
  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_nxt;

  always_comb begin
    disp_gnt_c = 1'b0;
    host_gnt_c = 1'b0;
    if (!ARESET) begin
      if (state_q == ST_HOST_FORCE) begin
        host_gnt_c = host_req;
        disp_gnt_c = disp_req && !host_req;
      end else begin
        disp_gnt_c = disp_req;
        host_gnt_c = host_req && !disp_req;
      end
    end
    starve_cnt_nxt = starve_cnt_q;
    if (!host_req || host_gnt_c) begin
      starve_cnt_nxt = '0;
    end else if (disp_gnt_c && starve_cnt_q != LIMIT) begin
      starve_cnt_nxt = starve_cnt_q + 8'd1;
    end
  end

  // Switch on the next count so the host wins the cycle right after the LIMIT-th display grant.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_DISP_PRI;
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_nxt;
      case (state_q)
        ST_DISP_PRI: begin
          if (host_req && !host_gnt_c && starve_cnt_nxt == LIMIT) begin
            state_q <= ST_HOST_FORCE;
          end
        end
        ST_HOST_FORCE: begin
          if (host_gnt_c || !host_req) begin
            state_q <= ST_DISP_PRI;
          end
        end
        default: state_q <= ST_DISP_PRI;
      endcase
    end
  end
`else
  always_comb begin
    disp_gnt_c = disp_req && !ARESET;
    host_gnt_c = host_req && !disp_req && !ARESET;
  end
`endif

  assign disp_gnt = disp_gnt_c;
  assign host_gnt = host_gnt_c;
  assign rd_issue = disp_gnt_c || (host_gnt_c && !host_we);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      bram_en <= disp_gnt_c || host_gnt_c;
      bram_we <= host_gnt_c && host_we;
      if (host_gnt_c) begin
        bram_addr <= host_addr;
      end else if (disp_gnt_c) begin
        bram_addr <= disp_addr;
      end
      if (host_gnt_c && host_we) begin
        bram_wdata <= host_wdata;
      end
    end
  end

  // Stage 0 lines up with bram_en; stage RD_LAT lines up with valid bram_rdata.
  logic [RD_LAT:0] tag_vld_q;
  logic [RD_LAT:0] tag_host_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tag_vld_q   <= '0;
      tag_host_q  <= '0;
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[RD_LAT-1:0], rd_issue};
      tag_host_q  <= {tag_host_q[RD_LAT-1:0], host_gnt_c};
      disp_rvalid <= tag_vld_q[RD_LAT] && !tag_host_q[RD_LAT];
      host_rvalid <= tag_vld_q[RD_LAT] && tag_host_q[RD_LAT];
      if (tag_vld_q[RD_LAT] && !tag_host_q[RD_LAT]) begin
        disp_rdata <= bram_rdata;
      end
      if (tag_vld_q[RD_LAT] && tag_host_q[RD_LAT]) begin
        host_rdata <= bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_bram_arbiter.sv
// Directed bench for vga_bram_arbiter with a one-cycle-latency BRAM model;
// starvation expectations follow VGA_BRAM_ARB_STARVE_GUARD_EN.
module tb_vga_bram_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [11:0] disp_rdata;
  logic        host_req;
  logic        host_we;
  logic [16:0] host_addr;
  logic [11:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [11:0] host_rdata;
  logic        bram_en;
  logic        bram_we;
  logic [16:0] bram_addr;
  logic [11:0] bram_wdata;
  logic [11:0] bram_rdata;

  always #5 ACLK = ~ACLK;

  vga_bram_arbiter #(
    .ADDR_W(17),
    .DATA_W(12),
    .RD_LAT(1),
    .STARVE_LIMIT(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM model: word i preloaded with value i.
  logic        preload;
  logic [11:0] mem [0:1023];
  always @(posedge ACLK) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 12'(i);
    end else if (bram_en) begin
      if (bram_we) mem[bram_addr[9:0]] <= bram_wdata;
      bram_rdata <= mem[bram_addr[9:0]];
    end
  end

  typedef struct {
    logic        rst;
    logic        dreq;
    logic [16:0] daddr;
    logic        hreq;
    logic        hwe;
    logic [16:0] haddr;
    logic [11:0] hwd;
    logic        e_dg;
    logic        e_hg;
    logic        e_en;
    logic        e_drv;
    logic        e_hrv;
    logic        chk_d;
    logic        chk_h;
    logic [11:0] e_drd;
    logic [11:0] e_hrd;
  } vec_t;

  vec_t vt [0:63];
  int   nv = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic dreq, input logic [16:0] daddr,
                   input logic hreq, input logic hwe, input logic [16:0] haddr,
                   input logic [11:0] hwd, input logic e_dg, input logic e_hg, input logic e_en);
    vt[nv].rst = rst;   vt[nv].dreq = dreq; vt[nv].daddr = daddr;
    vt[nv].hreq = hreq; vt[nv].hwe = hwe;   vt[nv].haddr = haddr; vt[nv].hwd = hwd;
    vt[nv].e_dg = e_dg; vt[nv].e_hg = e_hg; vt[nv].e_en = e_en;
    vt[nv].e_drv = 1'b0; vt[nv].e_hrv = 1'b0;
    vt[nv].chk_d = rst;  vt[nv].chk_h = rst;
    vt[nv].e_drd = '0;   vt[nv].e_hrd = '0;
    nv++;
  endtask

  task automatic drv_at(input int idx, input logic [11:0] d);
    vt[idx].e_drv = 1'b1; vt[idx].chk_d = 1'b1; vt[idx].e_drd = d;
  endtask

  task automatic hrv_at(input int idx, input logic [11:0] d);
    vt[idx].e_hrv = 1'b1; vt[idx].chk_h = 1'b1; vt[idx].e_hrd = d;
  endtask

  task automatic drive(input logic rst, input logic dreq, input logic [16:0] daddr,
                       input logic hreq, input logic hwe, input logic [16:0] haddr,
                       input logic [11:0] hwd);
    ARESET = rst; disp_req = dreq; disp_addr = daddr;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
  endtask

  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  int hrv_cnt;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    preload = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    preload = 1'b0;

    // Reset with both requesters active: everything must stay 0.
    for (int i = 0; i < 5; i++) v(1'b1, 1'b1, 17'd0, 1'b1, 1'b0, 17'd0, 12'h0, 1'b0, 1'b0, 1'b0);
    // Display streaming 0..15 straight out of reset (idx 5..20).
    for (int k = 0; k < 16; k++) v(1'b0, 1'b1, 17'(k), 1'b0, 1'b0, 17'd0, 12'h0, 1'b1, 1'b0, k >= 1);
    v(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 17'h10, 12'hABC, 1'b0, 1'b1, 1'b1); // 21 host write
    v(1'b0, 1'b0, 17'd0, 1'b1, 1'b0, 17'h10, 12'h0,   1'b0, 1'b1, 1'b1); // 22 host read
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b1); // 23
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 24
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 25
    v(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 17'h20, 12'h5A5, 1'b0, 1'b1, 1'b0); // 26 host write
    v(1'b0, 1'b1, 17'h20, 1'b0, 1'b0, 17'd0, 12'h0,   1'b1, 1'b0, 1'b1); // 27 display read same addr
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b1); // 28
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 29
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 30
    v(1'b0, 1'b1, 17'd5, 1'b1, 1'b0, 17'd7,  12'h0,   1'b1, 1'b0, 1'b0); // 31 contention
    v(1'b0, 1'b0, 17'd0, 1'b1, 1'b0, 17'd7,  12'h0,   1'b0, 1'b1, 1'b1); // 32 host served
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b1); // 33
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 34
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 35
    v(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0,  12'h0,   1'b0, 1'b0, 1'b0); // 36
    for (int k = 0; k < 16; k++) drv_at(8 + k, 12'(k));
    hrv_at(25, 12'hABC);
    drv_at(30, 12'h5A5);
    drv_at(34, 12'h005);
    hrv_at(35, 12'h007);

    for (int i = 0; i < nv; i++) begin
      drive(vt[i].rst, vt[i].dreq, vt[i].daddr, vt[i].hreq, vt[i].hwe, vt[i].haddr, vt[i].hwd);
      @(negedge ACLK);
      chk("disp_gnt", i, 32'(disp_gnt), 32'(vt[i].e_dg));
      chk("host_gnt", i, 32'(host_gnt), 32'(vt[i].e_hg));
      chk("bram_en", i, 32'(bram_en), 32'(vt[i].e_en));
      chk("disp_rvalid", i, 32'(disp_rvalid), 32'(vt[i].e_drv));
      chk("host_rvalid", i, 32'(host_rvalid), 32'(vt[i].e_hrv));
      if (vt[i].chk_d) chk("disp_rdata", i, 32'(disp_rdata), 32'(vt[i].e_drd));
      if (vt[i].chk_h) chk("host_rdata", i, 32'(host_rdata), 32'(vt[i].e_hrd));
      next_cycle();
    end

    // Reset one cycle after a host read grant: the read must never return.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h10, '0);
    @(negedge ACLK);
    chk("midrst_gnt", 0, 32'(host_gnt), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) ARESET = 1'b0;
      @(negedge ACLK);
      chk("midrst_hrv", c, 32'(host_rvalid), 32'd0);
      chk("midrst_drv", c, 32'(disp_rvalid), 32'd0);
      next_cycle();
    end
    // Post-reset host read of 0x10 and display read of 9.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h10, '0);
    @(negedge ACLK);
    chk("post_hgnt", 0, 32'(host_gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 17'd9, 1'b0, 1'b0, '0, '0);
    @(negedge ACLK);
    chk("post_dgnt", 1, 32'(disp_gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    @(negedge ACLK);
    chk("post_hrv", 3, 32'(host_rvalid), 32'd1);
    chk("post_hrdata", 3, 32'(host_rdata), 32'hABC);
    next_cycle();
    @(negedge ACLK);
    chk("post_drv", 4, 32'(disp_rvalid), 32'd1);
    chk("post_drdata", 4, 32'(disp_rdata), 32'h009);
    next_cycle();

    // Continuous display stream with a host read of address 3 held.
    hrv_cnt = 0;
`ifdef VGA_BRAM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 27; k++) begin
      drive(1'b0, 1'b1, 17'(k), 1'b1, 1'b0, 17'd3, '0);
      @(negedge ACLK);
      chk("starve_gnts", k, {30'd0, disp_gnt, host_gnt}, (k % 9 == 8) ? 32'b01 : 32'b10);
      if (host_rvalid) begin
        hrv_cnt++;
        chk("starve_hrdata", k, 32'(host_rdata), 32'h003);
      end
      next_cycle();
    end
`else
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b1, 17'(k), 1'b1, 1'b0, 17'd3, '0);
      @(negedge ACLK);
      chk("strict_gnts", k, {30'd0, disp_gnt, host_gnt}, 32'b10);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'd3, '0);
    @(negedge ACLK);
    chk("strict_release", 0, 32'(host_gnt), 32'd1);
    next_cycle();
`endif
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      if (host_rvalid) begin
        hrv_cnt++;
        chk("drain_hrdata", c, 32'(host_rdata), 32'h003);
      end
      next_cycle();
    end
`ifdef VGA_BRAM_ARB_STARVE_GUARD_EN
    chk("starve_hrv_count", 0, 32'(hrv_cnt), 32'd3);
`else
    chk("strict_hrv_count", 0, 32'(hrv_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
